// File: rtl/peripheral_sqrt_n.sv
// Memory-mapped integer square-root peripheral: one root bit per clock using
// the digit-by-digit method, with busy/done/overrun status and a done interrupt.
module peripheral_sqrt_n #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  output logic        irq
);

  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(H) + 1;

  localparam logic [4:0] A_RAD  = 5'h00;
  localparam logic [4:0] A_ROOT = 5'h04;
  localparam logic [4:0] A_REM  = 5'h08;
  localparam logic [4:0] A_CTRL = 5'h0C;

  logic [WIDTH-1:0] r_rad;
  logic [H-1:0]     r_q;
  logic [H+1:0]     r_r;
  logic [CW-1:0]    r_cnt;
  logic [H-1:0]     r_root;
  logic [H+1:0]     r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_ovr;
  logic             r_irq_en;
  logic             r_irq;
  logic [31:0]      r_dout;

  logic             w_rd;
  logic             w_wr;
  logic [H+3:0]     w_cat;
  logic [H+3:0]     w_sub;
  logic [H+3:0]     w_trial;
  logic             w_ge;
  logic [H+1:0]     w_r_nxt;
  logic [H-1:0]     w_q_nxt;
  logic [31:0]      w_rdata;
  logic             w_unused_din;

  assign w_rd = cs & rd;
  assign w_wr = cs & wr;

  // Upper data bits beyond the radicand/control fields are don't-care.
  assign w_unused_din = ^(d_in >> WIDTH);

  // Trial subtraction of {Q,01} from the remainder extended by the next pair.
  assign w_cat   = {r_r, r_rad[WIDTH-1:WIDTH-2]};
  assign w_sub   = {2'b00, r_q, 2'b01};
  assign w_ge    = (w_cat >= w_sub);
  assign w_trial = w_cat - w_sub;
  assign w_r_nxt = w_ge ? w_trial[H+1:0] : w_cat[H+1:0];
  assign w_q_nxt = {r_q[H-2:0], w_ge};

  always_comb begin
    w_rdata = '0;
    case (addr)
      A_ROOT:  w_rdata = 32'(r_root);
      A_REM:   w_rdata = 32'(r_rem);
      A_CTRL:  w_rdata = {28'd0, r_irq_en, r_ovr, r_done, r_busy};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rad    <= '0;
      r_q      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_root   <= '0;
      r_rem    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
      r_dout   <= '0;
    end else begin
      if (w_rd)
        r_dout <= w_rdata;
      r_irq <= r_done & r_irq_en;

      if (w_wr && addr == A_CTRL) begin
        r_irq_en <= d_in[0];
        if (d_in[1]) r_done <= 1'b0;
        if (d_in[2]) r_ovr  <= 1'b0;
      end

      if (w_wr && addr == A_RAD) begin
        if (r_busy) begin
          r_ovr <= 1'b1;
        end else begin
          r_rad  <= d_in[WIDTH-1:0];
          r_q    <= '0;
          r_r    <= '0;
          r_cnt  <= CW'(H);
          r_busy <= 1'b1;
          r_done <= 1'b0;
        end
      end

      // Placed after the control write so completion overrides a done clear.
      if (r_busy) begin
        r_rad <= {r_rad[WIDTH-3:0], 2'b00};
        r_q   <= w_q_nxt;
        r_r   <= w_r_nxt;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_root <= w_q_nxt;
          r_rem  <= w_r_nxt;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign d_out = r_dout;
  assign irq   = r_irq;

endmodule

// File: tb/tb_peripheral_sqrt_n.sv
// Directed bench for peripheral_sqrt_n at WIDTH=16 and WIDTH=32.
module tb_peripheral_sqrt_n;

  logic        clk;
  logic        reset;
  logic [31:0] d_in;
  logic        cs16, cs32;
  logic [4:0]  addr;
  logic        rd, wr;
  logic [31:0] d_out16, d_out32;
  logic        irq16, irq32;

  int unsigned ncheck;
  int unsigned nerr;

  peripheral_sqrt_n #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs16), .addr(addr),
    .rd(rd), .wr(wr), .d_out(d_out16), .irq(irq16)
  );

  peripheral_sqrt_n #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs32), .addr(addr),
    .rd(rd), .wr(wr), .d_out(d_out32), .irq(irq32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncheck++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Each bus task starts at a falling edge and ends at the next falling edge.
  task automatic bus(input bit s32, input bit w, input bit r, input logic [4:0] a,
                     input logic [31:0] d);
    cs16 = ~s32; cs32 = s32; wr = w; rd = r; addr = a; d_in = d;
    @(negedge clk);
    cs16 = 1'b0; cs32 = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; d_in = '0;
  endtask

  task automatic wreg(input bit s32, input logic [4:0] a, input logic [31:0] d);
    bus(s32, 1'b1, 1'b0, a, d);
  endtask

  task automatic chk_rd(input bit s32, input logic [4:0] a, input logic [31:0] exp,
                        input string tag);
    bus(s32, 1'b0, 1'b1, a, '0);
    check(tag, s32 ? d_out32 : d_out16, exp);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    ncheck = 0; nerr = 0;
    reset = 1'b1; cs16 = 0; cs32 = 0; rd = 0; wr = 0; addr = '0; d_in = '0;
    repeat (2) @(negedge clk);
    check("rst_dout", d_out16, 32'd0);
    check("rst_irq", {31'd0, irq16}, 32'd0);
    reset = 1'b0;
    chk_rd(0, 5'h0C, 32'h0, "rst_status");
    chk_rd(0, 5'h04, 32'h0, "rst_root");
    chk_rd(0, 5'h08, 32'h0, "rst_rem");

    // 144: busy on exactly 8 consecutive status reads, then done.
    wreg(0, 5'h00, 32'd144);
    for (int i = 0; i < 8; i++) chk_rd(0, 5'h0C, 32'h1, "busy_144");
    chk_rd(0, 5'h0C, 32'h2, "done_144");
    chk_rd(0, 5'h04, 32'd12, "root_144");
    chk_rd(0, 5'h08, 32'd0, "rem_144");

    wreg(0, 5'h00, 32'd150); idle(8);
    chk_rd(0, 5'h04, 32'd12, "root_150");
    chk_rd(0, 5'h08, 32'd6, "rem_150");
    wreg(0, 5'h00, 32'd0); idle(8);
    chk_rd(0, 5'h04, 32'd0, "root_0");
    chk_rd(0, 5'h08, 32'd0, "rem_0");
    wreg(0, 5'h00, 32'd65535); idle(8);
    chk_rd(0, 5'h04, 32'd255, "root_ffff");
    chk_rd(0, 5'h08, 32'd510, "rem_ffff");

    // Overrun: second start on cycle 3 is ignored.
    wreg(0, 5'h00, 32'd150); idle(2);
    wreg(0, 5'h00, 32'd9); idle(5);
    chk_rd(0, 5'h0C, 32'h6, "ovr_status");
    chk_rd(0, 5'h04, 32'd12, "ovr_root");
    chk_rd(0, 5'h08, 32'd6, "ovr_rem");
    wreg(0, 5'h0C, 32'h6);
    chk_rd(0, 5'h0C, 32'h0, "clr_status");
    wreg(0, 5'h04, 32'hFF);
    chk_rd(0, 5'h04, 32'd12, "ro_root");
    chk_rd(0, 5'h00, 32'd0, "rd_rad_zero");
    chk_rd(0, 5'h14, 32'd0, "rd_unmapped");

    // Interrupt path.
    wreg(0, 5'h0C, 32'h1);
    wreg(0, 5'h00, 32'd49); idle(8);
    check("irq_at_done", {31'd0, irq16}, 32'd0);
    idle(1);
    check("irq_after_done", {31'd0, irq16}, 32'd1);
    chk_rd(0, 5'h04, 32'd7, "root_49");
    wreg(0, 5'h0C, 32'h3);
    idle(1);
    check("irq_cleared", {31'd0, irq16}, 32'd0);
    chk_rd(0, 5'h0C, 32'h8, "irqen_kept");

    // Done clear on the completion edge loses to completion.
    wreg(0, 5'h00, 32'd4); idle(7);
    wreg(0, 5'h0C, 32'h2);
    chk_rd(0, 5'h0C, 32'h2, "done_wins");

    // Reset mid-operation.
    wreg(0, 5'h00, 32'd65535);
    chk_rd(0, 5'h04, 32'd2, "busy_prior_root16");
    idle(2);
    reset = 1'b1;
    #1;
    check("mid_rst_dout", d_out16, 32'd0);
    check("mid_rst_irq", {31'd0, irq16}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk_rd(0, 5'h0C, 32'h0, "mid_rst_status");
    chk_rd(0, 5'h04, 32'h0, "mid_rst_root");
    wreg(0, 5'h00, 32'd4); idle(8);
    chk_rd(0, 5'h04, 32'd2, "root_4");
    chk_rd(0, 5'h08, 32'd0, "rem_4");

    // WIDTH=32 instance.
    wreg(1, 5'h00, 32'd4); idle(16);
    chk_rd(1, 5'h04, 32'd2, "w32_root_4");
    wreg(1, 5'h00, 32'hFFFF_FFFF);
    chk_rd(1, 5'h04, 32'd2, "w32_busy_prior_root");
    idle(14);
    chk_rd(1, 5'h0C, 32'h1, "w32_busy_last");
    chk_rd(1, 5'h0C, 32'h2, "w32_done");
    chk_rd(1, 5'h04, 32'd65535, "w32_root_max");
    chk_rd(1, 5'h08, 32'd131070, "w32_rem_max");

    $display("Result: errors=%0d of %0d checks", nerr, ncheck);
    $finish;
  end

endmodule
